// File: rtl/spike_event_scheduler.sv
// Spike event scheduler: round-robin push arbitration of N_REQ requesters into
// an external FIFO, plus a three-state pop FSM that feeds a valid/ready sink.
module spike_event_scheduler #(
  parameter int N_REQ = 4,
  parameter int M     = 8,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*M-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               fifo_w_en_o,
  output logic [M-1:0]       fifo_w_data_o,
  input  logic               fifo_full_i,
  output logic               fifo_r_en_o,
  input  logic               fifo_empty_i,
  input  logic [M-1:0]       fifo_r_data_i,
  output logic               spk_valid_o,
  output logic [M-1:0]       spk_data_o,
  input  logic               spk_ready_i,
  output logic [CNT_W-1:0]   push_cnt_o,
  output logic [CNT_W-1:0]   pop_cnt_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [PTR_W-1:0] rr_ptr_reg;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic             push_go;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             r_en;
  logic             spk_valid_reg;
  logic [M-1:0]     spk_data_reg;
  logic [CNT_W-1:0] push_cnt_reg;
  logic [CNT_W-1:0] pop_cnt_reg;

  // Scan requesters starting at rr_ptr and wrapping; the first valid one wins.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  assign push_go       = !RST && en_i && !fifo_full_i && grant_found;
  assign fifo_w_en_o   = push_go;
  assign fifo_w_data_o = req_data_i[int'(grant_idx)*M +: M];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = push_go && (grant_idx == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    r_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en_i && !fifo_empty_i) begin
          r_en       = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: state_next = HOLD;
      HOLD: begin
        if (spk_ready_i) begin
          if (en_i && !fifo_empty_i) begin
            r_en       = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_r_en_o = r_en && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_reg    <= '0;
      state_reg     <= IDLE;
      spk_valid_reg <= 1'b0;
      spk_data_reg  <= '0;
      push_cnt_reg  <= '0;
      pop_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (push_go) begin
        rr_ptr_reg <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        if (push_cnt_reg != '1) push_cnt_reg <= push_cnt_reg + 1'b1;
      end
      // FIFO read data arrives one cycle after the read strobe, i.e. in FETCH.
      if (state_reg == FETCH) begin
        spk_data_reg  <= fifo_r_data_i;
        spk_valid_reg <= 1'b1;
      end else if (state_reg == HOLD && spk_ready_i) begin
        spk_valid_reg <= 1'b0;
      end
      if (spk_valid_reg && spk_ready_i && pop_cnt_reg != '1)
        pop_cnt_reg <= pop_cnt_reg + 1'b1;
    end
  end

  assign spk_valid_o = spk_valid_reg;
  assign spk_data_o  = spk_data_reg;
  assign push_cnt_o  = push_cnt_reg;
  assign pop_cnt_o   = pop_cnt_reg;

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Randomized bench for spike_event_scheduler against a transaction-level model
// of arbitration, pop latency and saturating counters, with a queue-based FIFO.
module tb_spike_event_scheduler;
  localparam int N     = 4;
  localparam int M     = 8;
  localparam int CW    = 5;
  localparam int DEPTH = 16;

  logic           CLK = 1'b0;
  logic           RST;
  logic           en_i;
  logic [N-1:0]   req_valid_i;
  logic [N*M-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic           fifo_w_en_o;
  logic [M-1:0]   fifo_w_data_o;
  logic           fifo_full_i;
  logic           fifo_r_en_o;
  logic           fifo_empty_i;
  logic [M-1:0]   fifo_r_data_i;
  logic           spk_valid_o;
  logic [M-1:0]   spk_data_o;
  logic           spk_ready_i;
  logic [CW-1:0]  push_cnt_o;
  logic [CW-1:0]  pop_cnt_o;

  always #5 CLK = ~CLK;

  spike_event_scheduler #(.N_REQ(N), .M(M), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .en_i(en_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .fifo_w_en_o(fifo_w_en_o), .fifo_w_data_o(fifo_w_data_o), .fifo_full_i(fifo_full_i),
    .fifo_r_en_o(fifo_r_en_o), .fifo_empty_i(fifo_empty_i), .fifo_r_data_i(fifo_r_data_i),
    .spk_valid_o(spk_valid_o), .spk_data_o(spk_data_o), .spk_ready_i(spk_ready_i),
    .push_cnt_o(push_cnt_o), .pop_cnt_o(pop_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the next cycle, set by the caller of step().
  bit           s_rst, s_en, s_ready, s_force_full;
  logic [N-1:0] s_valid;
  logic [N*M-1:0] s_data;

  // Reference model state.
  int         rr, age, pcnt, ccnt, last_grant;
  bit         inflight, last_w, last_r;
  logic [M-1:0] last_wd;
  logic [M-1:0] fifo_q[$];
  logic [M-1:0] exp_out[$];

  function automatic int sat_inc(input int v);
    return (v == (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic step();
    int g, idx;
    bit full, empty, exp_valid, exp_r, hs;
    logic [63:0] exp_rdy;
    @(negedge CLK);
    if (last_w) fifo_q.push_back(last_wd);
    if (last_r && fifo_q.size() > 0) begin
      fifo_r_data_i = fifo_q.pop_front();
      exp_out.push_back(fifo_r_data_i);
    end
    full  = s_force_full || (fifo_q.size() >= DEPTH);
    empty = (fifo_q.size() == 0);
    RST = s_rst; en_i = s_en; req_valid_i = s_valid; req_data_i = s_data;
    spk_ready_i = s_ready; fifo_full_i = full; fifo_empty_i = empty;
    #1;
    g = -1;
    if (!s_rst && s_en && !full)
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (g < 0 && s_valid[idx]) g = idx;
      end
    exp_rdy = (g >= 0) ? (64'd1 << g) : 64'd0;
    chk("req_ready", 64'(req_ready_o), exp_rdy);
    chk("w_en", 64'(fifo_w_en_o), 64'(g >= 0));
    if (g >= 0) chk("w_data", 64'(fifo_w_data_o), 64'(s_data[g*M +: M]));
    exp_valid = inflight && age >= 2;
    chk("spk_valid", 64'(spk_valid_o), 64'(exp_valid));
    exp_r = !s_rst && s_en && !empty && (!inflight || (exp_valid && s_ready));
    chk("r_en", 64'(fifo_r_en_o), 64'(exp_r));
    if (exp_valid) begin
      if (exp_out.size() > 0) chk("spk_data", 64'(spk_data_o), 64'(exp_out[0]));
      else chk("spk_data_avail", 64'(exp_out.size()), 64'd1);
    end
    chk("push_cnt", 64'(push_cnt_o), 64'(pcnt));
    chk("pop_cnt", 64'(pop_cnt_o), 64'(ccnt));
    hs = exp_valid && s_ready && !s_rst;
    last_grant = g;
    if (s_rst) begin
      rr = 0; inflight = 0; age = 0; pcnt = 0; ccnt = 0;
      exp_out.delete(); last_w = 0; last_r = 0;
    end else begin
      if (g >= 0) begin
        rr   = (g + 1) % N;
        pcnt = sat_inc(pcnt);
      end
      last_w  = (g >= 0);
      last_wd = (g >= 0) ? s_data[g*M +: M] : '0;
      if (hs) begin
        ccnt = sat_inc(ccnt);
        inflight = 0;
        if (exp_out.size() > 0) void'(exp_out.pop_front());
      end
      if (exp_r) begin
        inflight = 1; age = 1;
      end else if (inflight && age < 2) begin
        age++;
      end
      last_r = exp_r;
    end
  endtask

  initial begin
    RST = 1; en_i = 0; req_valid_i = '0; req_data_i = '0; spk_ready_i = 0;
    fifo_full_i = 0; fifo_empty_i = 1; fifo_r_data_i = '0;
    rr = 0; age = 0; pcnt = 0; ccnt = 0; inflight = 0; last_w = 0; last_r = 0;
    last_wd = '0; last_grant = -1;
    s_rst = 1; s_en = 0; s_ready = 0; s_force_full = 0; s_valid = '0; s_data = '0;
    repeat (2) step();
    s_rst = 0;
    step();
    chk("rst_spk_data", 64'(spk_data_o), 64'd0);

    // All requesters valid: grants rotate 0,1,2,3,0,1,2,3.
    s_en = 1; s_ready = 1; s_valid = '1;
    for (int i = 0; i < 8; i++) begin
      s_data = {$urandom, $urandom};
      step();
      chk("grant_seq", 64'(last_grant), 64'(i % N));
    end
    // Only requester 2 valid: grant 2 (ptr 0), then grant 2 again with ptr 3 wrapping.
    s_valid = 4'b0100;
    step(); chk("grant_r2a", 64'(last_grant), 64'd2);
    step(); chk("grant_r2b", 64'(last_grant), 64'd2);
    // FIFO full blocks all grants and keeps the pointer.
    s_force_full = 1; s_valid = '1;
    repeat (2) step();
    s_force_full = 0; s_valid = 4'b1111;
    step(); chk("grant_after_full", 64'(last_grant), 64'd3);

    // Backpressure, then reset in the middle of HOLD.
    s_valid = '0; s_ready = 0;
    repeat (8) step();
    s_rst = 1; step();
    s_rst = 0; step();
    chk("rst_hold_valid", 64'(spk_valid_o), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      s_rst        = ($urandom_range(0, 299) == 0);
      s_en         = ($urandom_range(0, 9) != 0);
      s_ready      = ($urandom_range(0, 9) < 6);
      s_force_full = ($urandom_range(0, 9) == 0);
      s_valid      = N'($urandom);
      s_data       = {$urandom, $urandom};
      step();
    end
    // Drain and make sure everything requested eventually reaches the sink.
    s_rst = 0; s_en = 1; s_ready = 1; s_force_full = 0; s_valid = '0;
    repeat (60) step();
    chk("drained_fifo", 64'(fifo_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_event_scheduler.md
SPIKE_EVENT_SCHEDULER -- requirements
Module: spike_event_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of spike-event requesters (≥2).
REQ-002 SHALL have parameter M, default 8, spike-event width in bits.
REQ-003 SHALL have parameter CNT_W, default 16, width of the event statistics counters.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en_i  input  1  scheduler enable; when 0, no new pushes and no new pops start.
REQ-007 SHALL have port req_valid_i  input  N_REQ  per-requester event valid.
REQ-008 SHALL have port req_data_i  input  N_REQ*M  per-requester event; requester i occupies bits [i*M +: M].
REQ-009 SHALL have port req_ready_o  output  N_REQ  per-requester accept; one-hot or zero.
REQ-010 SHALL have port fifo_w_en_o  output  1  FIFO write enable.
REQ-011 SHALL have port fifo_w_data_o  output  M  FIFO write data.
REQ-012 SHALL have port fifo_full_i  input  1  FIFO full flag.
REQ-013 SHALL have port fifo_r_en_o  output  1  FIFO read enable.
REQ-014 SHALL have port fifo_empty_i  input  1  FIFO empty flag.
REQ-015 SHALL have port fifo_r_data_i  input  M  FIFO read data; registered in the FIFO, valid the cycle after fifo_r_en_o.
REQ-016 SHALL have port spk_valid_o  output  1  downstream event valid.
REQ-017 SHALL have port spk_data_o  output  M  downstream event.
REQ-018 SHALL have port spk_ready_i  input  1  downstream accept.
REQ-019 SHALL have port push_cnt_o  output  CNT_W  number of events pushed, saturating.
REQ-020 SHALL have port pop_cnt_o  output  CNT_W  number of events delivered downstream, saturating.

Function
REQ-021 Push arbitration SHALL be round-robin: grant the lowest index ≥ rr_ptr with req_valid_i set, wrapping modulo N_REQ.
REQ-022 A grant SHALL occur only when en_i=1, fifo_full_i=0 and some req_valid_i bit is set; otherwise req_ready_o=0 and fifo_w_en_o=0.
REQ-023 On a grant g, req_ready_o[g]=1, fifo_w_en_o=1 and fifo_w_data_o=req_data_i[g]; all three SHALL be combinational in the same cycle.
REQ-024 After a grant g, rr_ptr SHALL become (g+1) mod N_REQ at the next edge; with no grant, rr_ptr SHALL hold.
REQ-025 The push path SHALL have a maximum throughput of one event per cycle.
REQ-026 The pop FSM SHALL have the states IDLE, FETCH and HOLD.
REQ-027 In IDLE, fifo_r_en_o SHALL be 1 when en_i=1 and fifo_empty_i=0, with next state FETCH; otherwise the FSM SHALL stay in IDLE.
REQ-028 In FETCH, fifo_r_en_o SHALL be 0; fifo_r_data_i SHALL be captured into spk_data_o; spk_valid_o SHALL be set; next state SHALL be HOLD.
REQ-029 In HOLD, spk_valid_o=1 and spk_data_o SHALL be held stable until spk_ready_i=1.
REQ-030 On HOLD with spk_ready_i=1, if en_i=1 and fifo_empty_i=0, fifo_r_en_o SHALL be 1 in that cycle and next state SHALL be FETCH with spk_valid_o cleared; otherwise next state SHALL be IDLE with spk_valid_o cleared.
REQ-031 Pop latency SHALL be: fifo_r_en_o at cycle t, spk_valid_o=1 from cycle t+2; sustained throughput is one event per 2 cycles.
REQ-032 Push and pop SHALL proceed independently in the same cycle; both may be active simultaneously.
REQ-033 Clearing en_i SHALL NOT abort an in-flight FETCH or HOLD; the current event completes, then the FSM stays in IDLE.
REQ-034 push_cnt_o SHALL increment on each cycle with fifo_w_en_o=1 and saturate at 2^CNT_W-1.
REQ-035 pop_cnt_o SHALL increment on each spk_valid_o&spk_ready_i cycle and saturate at 2^CNT_W-1.
REQ-036 fifo_r_en_o SHALL never be asserted while fifo_empty_i=1, and fifo_w_en_o SHALL never be asserted while fifo_full_i=1.

Reset
REQ-037 With RST=1 at a rising edge, the FSM SHALL go to IDLE and spk_valid_o, spk_data_o, rr_ptr, push_cnt_o and pop_cnt_o SHALL go to 0.
REQ-038 While RST=1, req_ready_o, fifo_w_en_o and fifo_r_en_o SHALL be 0.
REQ-039 Reset asserted mid-HOLD SHALL discard the held event without an accept; pop_cnt_o SHALL not increment.

Verification
REQ-040 Scenario: N_REQ=4, all valid for 8 cycles, FIFO not full -> grants 0,1,2,3,0,1,2,3; push_cnt_o=8.
REQ-041 Scenario: only requester 2 valid, rr_ptr=3 -> grant 2 (wrap); rr_ptr becomes 3.
REQ-042 Scenario: fifo_full_i=1 with all requesters valid -> req_ready_o=0000, fifo_w_en_o=0, rr_ptr unchanged.
REQ-043 Scenario: FIFO holds 0x5A, spk_ready_i=1 -> fifo_r_en_o at t, spk_valid_o=1 with spk_data_o=0x5A at t+2, pop_cnt_o=1 at t+3.
REQ-044 Scenario: spk_ready_i=0 for 5 cycles in HOLD -> spk_data_o stable, fifo_r_en_o=0 throughout; accept on the 6th cycle.
REQ-045 Scenario: RST pulsed during HOLD -> next cycle spk_valid_o=0, state IDLE, counters 0.
